fp_packet_rx_ctrl: RTL

FP_PACKET_RX_CTRL -- requirements
Module: fp_packet_rx_ctrl

---
 rtl/fp_packet_rx_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_packet_rx_ctrl.sv
// Fingerprint sensor packet receiver: parses EF 01 framed packets,
// checks address/length/checksum and buffers the payload for reading.
module fp_packet_rx_ctrl #(
  parameter logic [31:0] CHIP_ADDR    = 32'hFFFFFFFF,
  parameter int          MAX_PAYLOAD  = 32,
  parameter int          TIMEOUT_CLKS = 3480
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Rd_En,
  output logic [7:0] o_Rd_Data,
  output logic       o_Rd_Empty,
  output logic       o_Pkt_Done,
  output logic       o_Pkt_Err,
  output logic [2:0] o_Err_Code,
  output logic [7:0] o_Pid,
  output logic [8:0] o_Payload_Len,
  output logic       o_Busy
);

  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR2, S_ADDR, S_PID, S_LENH,
    S_LENL, S_DATA, S_SUMH, S_SUML
  } state_t;

  state_t state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  lenh_q, lenh_d;
  logic [7:0]  sumh_q, sumh_d;
  logic [15:0] sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] vis_q, vis_d;
  logic [7:0]  pidc_q, pidc_d;
  logic [7:0]  pid_q, pid_d;
  logic [8:0]  plen_q, plen_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  rdat_q;
  logic        empty_q;
  logic        we, fail;
  logic [2:0]  fcode;
  logic [15:0] len;
  logic [7:0]  mem [MAX_PAYLOAD];

  assign len = {lenh_q, i_Rx_Byte};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    lenh_d  = lenh_q;
    sumh_d  = sumh_q;
    sum_d   = sum_q;
    tmo_d   = tmo_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    vis_d   = vis_q;
    pidc_d  = pidc_q;
    pid_d   = pid_q;
    plen_d  = plen_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    we      = 1'b0;
    fail    = 1'b0;
    fcode   = 3'd0;
    if (i_Rd_En && !empty_q) rd_d = rd_q + PW'(1);
    if (state_q != S_IDLE)
      tmo_d = i_Rx_DV ? '0 : tmo_q + TW'(1);
    if (i_Rx_DV) begin
      unique case (state_q)
        S_IDLE: if (i_Rx_Byte == 8'hEF) begin
          state_d = S_HDR2;
          rd_d    = '0;
          wr_d    = '0;
          vis_d   = '0;
          sum_d   = '0;
          tmo_d   = '0;
        end
        S_HDR2: begin
          idx_d = '0;
          if (i_Rx_Byte == 8'h01) state_d = S_ADDR;
          else if (i_Rx_Byte != 8'hEF) state_d = S_IDLE;
        end
        S_ADDR: begin
          addr_d = {addr_q[15:0], i_Rx_Byte};
          idx_d  = idx_q + 9'd1;
          if (idx_q == 9'd3) begin
            if ({addr_q, i_Rx_Byte} == CHIP_ADDR) state_d = S_PID;
            else begin fail = 1'b1; fcode = 3'd1; end
          end
        end
        S_PID: begin
          pidc_d  = i_Rx_Byte;
          sum_d   = sum_q + 16'(i_Rx_Byte);
          state_d = S_LENH;
        end
        S_LENH: begin
          lenh_d  = i_Rx_Byte;
          sum_d   = sum_q + 16'(i_Rx_Byte);
          state_d = S_LENL;
        end
        S_LENL: begin
          sum_d = sum_q + 16'(i_Rx_Byte);
          idx_d = 9'(len - 16'd2);
          if (len < 16'd2 || len > 16'(MAX_PAYLOAD + 2)) begin
            fail  = 1'b1;
            fcode = 3'd2;
          end else if (len == 16'd2) state_d = S_SUMH;
          else state_d = S_DATA;
        end
        S_DATA: begin
          we    = 1'b1;
          wr_d  = wr_q + PW'(1);
          sum_d = sum_q + 16'(i_Rx_Byte);
          idx_d = idx_q - 9'd1;
          if (idx_q == 9'd1) state_d = S_SUMH;
        end
        S_SUMH: begin
          sumh_d  = i_Rx_Byte;
          state_d = S_SUML;
        end
        S_SUML: begin
          state_d = S_IDLE;
          if ({sumh_q, i_Rx_Byte} == sum_q) begin
            done_d = 1'b1;
            pid_d  = pidc_q;
            plen_d = 9'(wr_q);
            vis_d  = wr_q;
          end else begin
            fail  = 1'b1;
            fcode = 3'd3;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
      fail  = 1'b1;
      fcode = 3'd4;
    end
    if (fail) begin
      err_d   = 1'b1;
      code_d  = fcode;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      lenh_q  <= '0;
      sumh_q  <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      vis_q   <= '0;
      pidc_q  <= '0;
      pid_q   <= '0;
      plen_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      rdat_q  <= '0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      lenh_q  <= lenh_d;
      sumh_q  <= sumh_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      vis_q   <= vis_d;
      pidc_q  <= pidc_d;
      pid_q   <= pid_d;
      plen_q  <= plen_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      rdat_q  <= mem[rd_d[AW-1:0]];
      empty_q <= (rd_d == vis_d);
    end
  end

  // Payload RAM has no reset; only committed bytes are ever visible
  always_ff @(posedge i_Clock) begin
    if (we && !i_Reset) mem[wr_q[AW-1:0]] <= i_Rx_Byte;
  end

  assign o_Rd_Data     = rdat_q;
  assign o_Rd_Empty    = empty_q;
  assign o_Pkt_Done    = done_q;
  assign o_Pkt_Err     = err_q;
  assign o_Err_Code    = code_q;
  assign o_Pid         = pid_q;
  assign o_Payload_Len = plen_q;
  assign o_Busy        = (state_q != S_IDLE);

endmodule
